elastic_pipeline: RTL and testbench

Parametrised valid/ready pipeline of NUM_STAGES register slices carrying DATA_WIDTH-bit words. It is the successor to the basic pipeline and adds three things: a selectable skid-buffer mode that registers the ready path, a synchronous flush, and an optional occupancy counter. It sits on any streaming datapath that needs retiming or latency balancing under backpressure.

---
 rtl/elastic_pipeline_pkg.sv | 25 ++
 rtl/elastic_pipeline_stage.sv | 120 ++++++++++++
 rtl/elastic_pipeline.sv | 104 ++++++++++
 tb/tb_elastic_pipeline.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elastic_pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipeline_pkg
// Description : Shared types and sizing helpers for the elastic pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package elastic_pipeline_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    function automatic int calc_cap(input int num_stages, input int skid);
        return num_stages * ((skid != 0) ? 2 : 1);
    endfunction

    // A zero-capacity pipeline still gets a 1-bit counter so the port is legal.
    function automatic int calc_cnt_w(input int cap);
        return (cap < 1) ? 1 : $clog2(cap + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/elastic_pipeline_stage.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipeline_stage
// Description : One valid/ready register slice; single-entry (SKID=0) or
//               two-entry skid slice with registered ready (SKID=1).
// Revision    : 1.0 - initial release
// ============================================================================
module elastic_pipeline_stage
    import elastic_pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SKID       = 0
) (
    input  logic                  clk_i,
    input  logic                  arst_n,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] up_data_i,
    input  logic                  up_valid_i,
    output logic                  up_ready_o,
    output logic [DATA_WIDTH-1:0] dn_data_o,
    output logic                  dn_valid_o,
    input  logic                  dn_ready_i
);

    generate
        if (SKID == 0) begin : g_single
            logic                  valid_q, valid_d;
            logic [DATA_WIDTH-1:0] data_q, data_d;

            assign up_ready_o = !valid_q || dn_ready_i;
            assign dn_valid_o = valid_q;
            assign dn_data_o  = data_q;

            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                if (up_valid_i && up_ready_o) begin
                    valid_d = 1'b1;
                    data_d  = up_data_i;
                end else if (dn_ready_i) begin
                    valid_d = 1'b0;
                end
                if (flush_i) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk_i or negedge arst_n) begin
                if (!arst_n) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end
        end else begin : g_skid
            skid_state_e           state_q, state_d;
            logic [DATA_WIDTH-1:0] main_q, main_d;
            logic [DATA_WIDTH-1:0] skid_q, skid_d;
            logic                  push;
            logic                  pop;

            // Ready depends only on registered state, breaking the ready chain.
            assign up_ready_o = (state_q != TWO);
            assign dn_valid_o = (state_q != EMPTY);
            assign dn_data_o  = main_q;
            assign push       = up_valid_i && up_ready_o;
            assign pop        = dn_valid_o && dn_ready_i;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                case (state_q)
                    EMPTY: begin
                        if (push) begin
                            main_d  = up_data_i;
                            state_d = ONE;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            main_d = up_data_i;
                        end else if (push) begin
                            skid_d  = up_data_i;
                            state_d = TWO;
                        end else if (pop) begin
                            state_d = EMPTY;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            main_d  = skid_q;
                            state_d = ONE;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
                if (flush_i) begin
                    state_d = EMPTY;
                end
            end

            always_ff @(posedge clk_i or negedge arst_n) begin
                if (!arst_n) begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/elastic_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipeline
// Description : NUM_STAGES chained valid/ready slices with synchronous flush.
//               Define ELASTIC_PIPELINE_OCCUPANCY_EN to add count_o/empty_o.
// Revision    : 1.0 - initial release
// ============================================================================
module elastic_pipeline
    import elastic_pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_STAGES = 4,
    parameter int SKID       = 0
) (
    input  logic                  clk_i,
    input  logic                  arst_n,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    ,
    output logic [calc_cnt_w(calc_cap(NUM_STAGES, SKID))-1:0] count_o,
    output logic                  empty_o
`endif
);

    generate
        if (NUM_STAGES == 0) begin : g_passthrough
            assign data_out       = data_in;
            assign data_out_valid = data_in_valid && !flush_i;
            assign data_in_ready  = data_out_ready && !flush_i;
        end else begin : g_chain
            logic [DATA_WIDTH-1:0] data_w  [NUM_STAGES+1];
            logic                  valid_w [NUM_STAGES+1];
            logic                  ready_w [NUM_STAGES+1];

            assign data_w[0]           = data_in;
            assign valid_w[0]          = data_in_valid;
            assign ready_w[NUM_STAGES] = data_out_ready;

            for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
                elastic_pipeline_stage #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .SKID       (SKID)
                ) u_stage (
                    .clk_i      (clk_i),
                    .arst_n     (arst_n),
                    .flush_i    (flush_i),
                    .up_data_i  (data_w[i]),
                    .up_valid_i (valid_w[i]),
                    .up_ready_o (ready_w[i]),
                    .dn_data_o  (data_w[i+1]),
                    .dn_valid_o (valid_w[i+1]),
                    .dn_ready_i (ready_w[i+1])
                );
            end

            // Stages clear themselves on flush; the ports are masked so no
            // transfer is visible at either boundary in the flush cycle.
            assign data_in_ready  = ready_w[0] && !flush_i;
            assign data_out_valid = valid_w[NUM_STAGES] && !flush_i;
            assign data_out       = data_w[NUM_STAGES];
        end
    endgenerate

`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    localparam int c_CNT_W = calc_cnt_w(calc_cap(NUM_STAGES, SKID));

    logic [c_CNT_W-1:0] count_q, count_d;
    logic               push;
    logic               pop;

    assign push = data_in_valid && data_in_ready;
    assign pop  = data_out_valid && data_out_ready;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : tb_elastic_pipeline
// Description : Scoreboard bench for an 8-stage single slice, a 4-stage skid
//               pipeline and a zero-stage passthrough instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elastic_pipeline;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       flush;
    logic [7:0] din  [2];
    logic [7:0] dout [2];
    logic       vin  [2];
    logic       rin  [2];
    logic       vout [2];
    logic       rout [2];
    logic       took [2];
    logic [7:0] pt_din, pt_dout;
    logic       pt_vin, pt_rin, pt_vout, pt_rout;
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    logic [3:0] cnt [2];
    logic       emp [2];
    logic       pt_cnt, pt_emp;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [7:0] sbq [2][$];
    int         out_cnt [2] = '{0, 0};
    int         acc_cnt [2] = '{0, 0};
    logic       hold_q  [2] = '{1'b0, 1'b0};
    logic [7:0] hold_d  [2] = '{8'h00, 8'h00};
    bit         lat_arm = 1'b0;
    int         acc_cyc = -1;
    int         out_cyc = -1;
    int         last_cyc = -1;
    int         a0 [2];
    int         o0 [2];
    int         k;
    logic [7:0] nv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    elastic_pipeline #(.DATA_WIDTH(8), .NUM_STAGES(8), .SKID(0)) u_s0 (
        .clk_i(clk), .arst_n(arst_n), .flush_i(flush),
        .data_in(din[0]), .data_in_valid(vin[0]), .data_in_ready(rin[0]),
        .data_out(dout[0]), .data_out_valid(vout[0]), .data_out_ready(rout[0])
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
        , .count_o(cnt[0]), .empty_o(emp[0])
`endif
    );

    elastic_pipeline #(.DATA_WIDTH(8), .NUM_STAGES(4), .SKID(1)) u_s1 (
        .clk_i(clk), .arst_n(arst_n), .flush_i(flush),
        .data_in(din[1]), .data_in_valid(vin[1]), .data_in_ready(rin[1]),
        .data_out(dout[1]), .data_out_valid(vout[1]), .data_out_ready(rout[1])
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
        , .count_o(cnt[1]), .empty_o(emp[1])
`endif
    );

    elastic_pipeline #(.DATA_WIDTH(8), .NUM_STAGES(0), .SKID(0)) u_pt (
        .clk_i(clk), .arst_n(arst_n), .flush_i(flush),
        .data_in(pt_din), .data_in_valid(pt_vin), .data_in_ready(pt_rin),
        .data_out(pt_dout), .data_out_valid(pt_vout), .data_out_ready(pt_rout)
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
        , .count_o(pt_cnt), .empty_o(pt_emp)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transfers are judged at the falling edge, where inputs and the
    // combinational ready/valid are settled for the coming rising edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!arst_n || flush) begin
                sbq[d].delete();
                hold_q[d] = 1'b0;
            end else begin
                if (hold_q[d]) begin
                    check_eq($sformatf("s%0d hold valid", d), 32'(vout[d]), 32'd1);
                    check_eq($sformatf("s%0d hold data", d), 32'(dout[d]), 32'(hold_d[d]));
                end
                if (vin[d] && rin[d]) begin
                    sbq[d].push_back(din[d]);
                    acc_cnt[d]++;
                    if (d == 0 && lat_arm && acc_cyc < 0) acc_cyc = cyc;
                end
                if (vout[d] && rout[d]) begin
                    out_cnt[d]++;
                    if (d == 0 && lat_arm) begin
                        if (out_cyc < 0) out_cyc = cyc;
                        last_cyc = cyc;
                    end
                    check_eq($sformatf("s%0d word expected", d), 32'(sbq[d].size() != 0), 32'd1);
                    if (sbq[d].size() != 0)
                        check_eq($sformatf("s%0d data", d), 32'(dout[d]), 32'(sbq[d].pop_front()));
                end
                hold_q[d] = vout[d] && !rout[d];
                hold_d[d] = dout[d];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        arst_n = 1'b0;
        flush  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            din[d] = '0; vin[d] = 1'b0; rout[d] = 1'b0; took[d] = 1'b0;
        end
        pt_din = '0; pt_vin = 1'b0; pt_rout = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("s%0d rst valid", d), 32'(vout[d]), 32'd0);
            check_eq($sformatf("s%0d rst data", d), 32'(dout[d]), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("s%0d post-rst ready", d), 32'(rin[d]), 32'd1);
            check_eq($sformatf("s%0d post-rst valid", d), 32'(vout[d]), 32'd0);
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
            check_eq($sformatf("s%0d post-rst count", d), 32'(cnt[d]), 32'd0);
            check_eq($sformatf("s%0d post-rst empty", d), 32'(emp[d]), 32'd1);
`endif
        end
        check_eq("pt ready no dn", 32'(pt_rin), 32'd0);

        // Passthrough: purely combinational, checked between edges.
        pt_din = 8'h5C; pt_vin = 1'b1; pt_rout = 1'b1;
        #1;
        check_eq("pt data", 32'(pt_dout), 32'h5C);
        check_eq("pt valid", 32'(pt_vout), 32'd1);
        check_eq("pt ready hi", 32'(pt_rin), 32'd1);
        pt_rout = 1'b0;
        #1;
        check_eq("pt ready lo", 32'(pt_rin), 32'd0);
        pt_rout = 1'b1; flush = 1'b1;
        #1;
        check_eq("pt flush valid", 32'(pt_vout), 32'd0);
        check_eq("pt flush ready", 32'(pt_rin), 32'd0);
        flush = 1'b0; pt_vin = 1'b0;

        // Latency and ordering on the 8-stage single-slice pipeline.
        tick();
        lat_arm = 1'b1;
        rout[0] = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            din[0] = i[7:0];
            vin[0] = 1'b1;
            tick();
        end
        vin[0] = 1'b0;
        repeat (20) tick();
        lat_arm = 1'b0;
        check_eq("s0 latency", 32'(out_cyc - acc_cyc), 32'd8);
        check_eq("s0 no gaps", 32'(last_cyc - out_cyc), 32'd15);
        check_eq("s0 burst drained", 32'(sbq[0].size()), 32'd0);

        // Random traffic with heavy backpressure on both pipelined instances.
        for (int d = 0; d < 2; d++) begin
            a0[d] = acc_cnt[d]; o0[d] = out_cnt[d]; took[d] = 1'b0;
        end
        for (int i = 0; i < 50; i++) begin
            for (int d = 0; d < 2; d++) begin
                if (!(vin[d] && !took[d])) begin
                    vin[d] = 1'($urandom_range(0, 1));
                    din[d] = 8'($urandom_range(0, 255));
                end
                rout[d] = ($urandom_range(0, 5) == 0);
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) took[d] = vin[d] && rin[d];
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            vin[d] = 1'b0; rout[d] = 1'b1;
        end
        k = 0;
        while (k < 64 && (sbq[0].size() != 0 || sbq[1].size() != 0)) begin
            tick();
            k++;
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("s%0d rand drained", d), 32'(sbq[d].size()), 32'd0);
            check_eq($sformatf("s%0d rand out=acc", d), 32'(out_cnt[d] - o0[d]), 32'(acc_cnt[d] - a0[d]));
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
            check_eq($sformatf("s%0d rand count", d), 32'(cnt[d]), 32'd0);
`endif
        end

        // Fill and stall the skid pipeline: capacity is 4 stages x 2 entries.
        rout[1] = 1'b0;
        a0[1] = acc_cnt[1]; o0[1] = out_cnt[1];
        nv = 8'h40;
        for (int i = 0; i < 16; i++) begin
            din[1] = nv;
            vin[1] = 1'b1;
            @(negedge clk);
            took[1] = rin[1];
            tick();
            if (took[1]) nv = nv + 8'd1;
        end
        check_eq("s1 fill accepted", 32'(acc_cnt[1] - a0[1]), 32'd8);
        check_eq("s1 full ready", 32'(rin[1]), 32'd0);
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
        check_eq("s1 full count", 32'(cnt[1]), 32'd8);
        check_eq("s1 full empty", 32'(emp[1]), 32'd0);
`endif
        vin[1] = 1'b0;
        rout[1] = 1'b1;
        // Registered ready frees one slice per edge, from the output backwards.
        k = 0;
        while (k < 10 && !rin[1]) begin
            tick();
            k++;
        end
        check_eq("s1 ready return", 32'(k), 32'd4);
        repeat (12) tick();
        check_eq("s1 fill out", 32'(out_cnt[1] - o0[1]), 32'd8);
        check_eq("s1 fill drained", 32'(sbq[1].size()), 32'd0);

        // Flush with four words held in each pipeline.
        for (int d = 0; d < 2; d++) begin
            rout[d] = 1'b0; a0[d] = acc_cnt[d];
        end
        for (int i = 0; i < 4; i++) begin
            for (int d = 0; d < 2; d++) begin
                din[d] = 8'h60 + 8'(i); vin[d] = 1'b1;
            end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("s%0d pre-flush acc", d), 32'(acc_cnt[d] - a0[d]), 32'd4);
            din[d] = 8'h77; vin[d] = 1'b1; rout[d] = 1'b1;
        end
        flush = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("s%0d flush ready", d), 32'(rin[d]), 32'd0);
            check_eq($sformatf("s%0d flush valid", d), 32'(vout[d]), 32'd0);
        end
        tick();
        flush = 1'b0;
        for (int d = 0; d < 2; d++) vin[d] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("s%0d post-flush valid", d), 32'(vout[d]), 32'd0);
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
            check_eq($sformatf("s%0d post-flush count", d), 32'(cnt[d]), 32'd0);
`endif
            o0[d] = out_cnt[d];
            din[d] = 8'hAA; vin[d] = 1'b1;
        end
        tick();
        for (int d = 0; d < 2; d++) vin[d] = 1'b0;
        repeat (12) tick();
        for (int d = 0; d < 2; d++)
            check_eq($sformatf("s%0d post-flush outs", d), 32'(out_cnt[d] - o0[d]), 32'd1);

        // Asynchronous reset with three words in flight and the output stalled.
        for (int d = 0; d < 2; d++) rout[d] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int d = 0; d < 2; d++) begin
                din[d] = 8'hC0 + 8'(i); vin[d] = 1'b1;
            end
            tick();
        end
        for (int d = 0; d < 2; d++) vin[d] = 1'b0;
        repeat (10) tick();
        for (int d = 0; d < 2; d++)
            check_eq($sformatf("s%0d pre-rst valid", d), 32'(vout[d]), 32'd1);
        #2 arst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("s%0d async rst valid", d), 32'(vout[d]), 32'd0);
            check_eq($sformatf("s%0d async rst data", d), 32'(dout[d]), 32'd0);
        end
        @(posedge clk);
        #3 arst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            o0[d] = out_cnt[d]; rout[d] = 1'b1;
        end
        repeat (15) tick();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("s%0d no stale outs", d), 32'(out_cnt[d] - o0[d]), 32'd0);
            check_eq($sformatf("s%0d ready after rst", d), 32'(rin[d]), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
